// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   state_t : FSM encoding (IDLE, BUSY, DONE)
//   DW_DEF  : default dividend/quotient width
//   VW_DEF  : default divisor width
package div_pkg;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
//   part_in  : partial remainder before the step (VW+1 bits)
//   bit_in   : next dividend bit, MSB first
//   divisor  : unsigned divisor
//   part_out : partial remainder after the step
//   q_bit    : quotient bit produced by this step
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   part_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   part_out,
    output logic          q_bit
);

    // One extra bit on the shifted value so the compare and subtract can
    // never wrap, whatever the partial remainder holds.
    logic [VW+1:0] shifted;
    logic [VW+1:0] dvs_ext;

    assign shifted  = {part_in, bit_in};
    assign dvs_ext  = {2'b00, divisor};
    assign q_bit    = (shifted >= dvs_ext);
    // After a restoring step the value is always below the divisor,
    // so dropping the top bit loses nothing.
    assign part_out = (VW+1)'(q_bit ? (shifted - dvs_ext) : shifted);

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider, one quotient bit per clock.
//   clk, rst             : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    : operand handshake, a (DW bits) / b (VW bits)
//   out_valid/out_ready  : result handshake
//   quotient, remainder  : a / b and a mod b (zero-extended), held in DONE
//   dbz                  : divide-by-zero flag, qualified by out_valid
module div_seq
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          dbz
);

    localparam int CW = $clog2(DW);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd;   // dividend shifts out the top, quotient bits shift in
    logic [VW:0]   part;
    logic [VW-1:0] dvs;

    logic [VW:0]   part_nxt;
    logic          q_bit;
    logic [DW-1:0] dvd_nxt;

    div_step #(.VW(VW)) u_step (
        .part_in  (part),
        .bit_in   (dvd[DW-1]),
        .divisor  (dvs),
        .part_out (part_nxt),
        .q_bit    (q_bit)
    );

    assign dvd_nxt = {dvd[DW-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            cnt       <= '0;
            dvd       <= '0;
            part      <= '0;
            dvs       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd      <= a;
                        dvs      <= b;
                        part     <= '0;
                        in_ready <= 1'b0;
                        if (b == '0) begin
                            // No iterations needed: report all-ones quotient.
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quotient  <= '1;
                            remainder <= a;
                            dbz       <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= CW'(DW - 1);
                            dbz   <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    part <= part_nxt;
                    dvd  <= dvd_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= dvd_nxt;
                        remainder <= DW'(part_nxt);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning dividend and quotient width (DW >= 2).
REQ-002 The block SHALL have parameter VW, default 8, meaning divisor width (1 <= VW <= DW).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a, input, DW bits: unsigned dividend.
REQ-008 The block SHALL have port b, input, VW bits: unsigned divisor.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 The block SHALL have port quotient, output, DW bits: a / b.
REQ-012 The block SHALL have port remainder, output, DW bits: a mod b, zero-extended.
REQ-013 The block SHALL have port dbz, output, 1 bit: divide-by-zero flag, qualified by out_valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 An accept SHALL occur on an edge where in_valid and in_ready are both 1; a and b SHALL be registered at that edge.
REQ-017 On an accept with b != 0, the state SHALL go to BUSY and the iteration counter SHALL load DW-1.
REQ-018 In BUSY, each edge SHALL perform one radix-2 restoring step, MSB first: shift the partial remainder left, bring in the next dividend bit, subtract the divisor when partial >= divisor, and set the corresponding quotient bit.
REQ-019 The partial remainder SHALL be VW+1 bits wide so the compare cannot overflow.
REQ-020 After DW BUSY edges (counter at 0), the state SHALL go to DONE; out_valid SHALL rise exactly DW edges after the accept edge.
REQ-021 On an accept with b == 0, the state SHALL go directly to DONE with quotient all ones, remainder = a and dbz = 1; out_valid SHALL be 1 in the cycle after the accept.
REQ-022 dbz SHALL be 0 for any nonzero divisor.
REQ-023 In DONE, quotient, remainder and dbz SHALL stay stable until an edge with out_ready = 1; that edge SHALL return the state to IDLE.
REQ-024 in_valid and operand changes while in BUSY or DONE SHALL be ignored, with no overlap of operations.
REQ-025 For a < b, the result SHALL be quotient = 0 and remainder = a.
REQ-026 For every nonzero divisor, quotient*b + remainder SHALL equal a, with remainder < b.

Reset
REQ-027 On an rst edge, the state SHALL become IDLE, and quotient, remainder, dbz, out_valid, the counter and the working registers SHALL all be 0.
REQ-028 While rst is held, in_ready SHALL be 1.
REQ-029 rst SHALL take priority over every other event, including an in-flight BUSY operation, which SHALL be discarded.
REQ-030 An rst asserted in the same cycle as in_valid SHALL NOT cause an accept.

Structure
REQ-031 Package div_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the default DW and VW constants.
REQ-032 The single restoring step (compare, subtract, quotient bit) SHALL be a combinational sub-module, div_step, parameterised by VW.
REQ-033 The counter SHALL be $clog2(DW) bits wide.

Verification (DW=16, VW=8)
REQ-034 Scenario: a=1000, b=7 -> out_valid exactly 16 cycles after accept; quotient=142, remainder=6, dbz=0.
REQ-035 Scenario: a=0xFFFF, b=1 -> quotient=0xFFFF, remainder=0; then a=100, b=200 -> quotient=0, remainder=100.
REQ-036 Scenario: a=5, b=0 -> out_valid in the cycle after accept; quotient=0xFFFF, remainder=5, dbz=1.
REQ-037 Scenario: out_ready held 0 for 5 cycles in DONE -> outputs unchanged and in_ready=0; out_ready=1 -> IDLE the next cycle, in_ready=1.
REQ-038 Scenario: rst pulsed at BUSY cycle 8 -> next cycle IDLE, all outputs 0, in_ready=1; a new a=81, b=9 -> quotient=9, remainder=0.
REQ-039 Scenario: random sweep of 10k operand pairs -> the REQ-026 invariant is checked on every result.
